// File: rtl/mig_ui_arbiter.sv
// rtl/mig_ui_arbiter.sv - two-requester round-robin arbiter/sequencer for the MIG user interface.
// Define ARB_FIXED_PRIO_EN to make r0 always win ties instead of round-robin.
module mig_ui_arbiter #(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_wack,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_rvalid,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_wack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_rvalid,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  input  logic              app_rd_data_end,
  output logic              rd_err
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WD0, S_WD1} state_t;

  state_t              r_state;
  logic                r_sel;
  logic                r_we;
  logic                r_last_gnt;
  logic                r_app_en;
  logic [2:0]          r_app_cmd;
  logic [ADDR_W-1:0]   r_app_addr;
  logic                r_wdf_wren;
  logic                r_wdf_end;
  logic                r_tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_rd_err;

  logic w_elig0, w_elig1, w_pick, w_push, w_pop, w_nonempty, w_head;

  // Reads need a free tag slot; writes never do.
  assign w_elig0    = r0_req & (r0_we | (r_count < FULL_CNT));
  assign w_elig1    = r1_req & (r1_we | (r_count < FULL_CNT));
`ifdef ARB_FIXED_PRIO_EN
  assign w_pick     = ~w_elig0;
`else
  assign w_pick     = (w_elig0 & w_elig1) ? ~r_last_gnt : w_elig1;
`endif
  assign w_push     = r_app_en & app_rdy & ~r_we;
  assign w_nonempty = (r_count != '0);
  assign w_head     = r_tag_mem[r_rd_ptr];
  assign w_pop      = app_rd_data_valid & app_rd_data_end & w_nonempty;

  assign app_en       = r_app_en;
  assign app_cmd      = r_app_cmd;
  assign app_addr     = r_app_addr;
  assign app_wdf_wren = r_wdf_wren;
  assign app_wdf_end  = r_wdf_end;
  assign app_wdf_data = r_wdf_wren ? (r_sel ? r1_wdata : r0_wdata) : '0;
  assign r0_gnt       = r_app_en & app_rdy & ~r_sel;
  assign r1_gnt       = r_app_en & app_rdy & r_sel;
  assign r0_wack      = r_wdf_wren & app_wdf_rdy & ~r_sel;
  assign r1_wack      = r_wdf_wren & app_wdf_rdy & r_sel;
  assign r0_rdata     = app_rd_data;
  assign r1_rdata     = app_rd_data;
  assign r0_rvalid    = app_rd_data_valid & w_nonempty & ~w_head;
  assign r1_rvalid    = app_rd_data_valid & w_nonempty & w_head;
  assign rd_err       = r_rd_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_last_gnt <= 1'b1;
      r_app_en   <= 1'b0;
      r_app_cmd  <= 3'b000;
      r_app_addr <= '0;
      r_wdf_wren <= 1'b0;
      r_wdf_end  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_elig0 | w_elig1) begin
            r_sel      <= w_pick;
            r_we       <= w_pick ? r1_we : r0_we;
            r_app_cmd  <= (w_pick ? r1_we : r0_we) ? 3'b000 : 3'b001;
            r_app_addr <= w_pick ? r1_addr : r0_addr;
            r_app_en   <= 1'b1;
            r_state    <= S_CMD;
          end
        end
        S_CMD: begin
          if (app_rdy) begin
            r_app_en <= 1'b0;
            if (r_we) begin
              r_wdf_wren <= 1'b1;
              r_wdf_end  <= 1'b0;
              r_state    <= S_WD0;
            end else begin
              r_last_gnt <= r_sel;
              r_state    <= S_IDLE;
            end
          end
        end
        S_WD0: begin
          if (app_wdf_rdy) begin
            r_wdf_end <= 1'b1;
            r_state   <= S_WD1;
          end
        end
        S_WD1: begin
          if (app_wdf_rdy) begin
            r_wdf_wren <= 1'b0;
            r_wdf_end  <= 1'b0;
            r_last_gnt <= r_sel;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag FIFO: one entry per outstanding read, popped on the last beat of each return burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rd_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (app_rd_data_valid & ~w_nonempty) r_rd_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= r_sel;
  end

endmodule

// File: tb/tb_mig_ui_arbiter.sv
// tb/tb_mig_ui_arbiter.sv - directed self-checking bench for mig_ui_arbiter.
module tb_mig_ui_arbiter;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [ADDR_W-1:0] r0_addr = '0, r1_addr = '0;
  logic [DATA_W-1:0] r0_wdata = '0, r1_wdata = '0;
  logic              r0_gnt, r0_wack, r0_rvalid, r1_gnt, r1_wack, r1_rvalid;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en, app_wdf_wren, app_wdf_end, rd_err;
  logic              app_rdy = 0, app_wdf_rdy = 0;
  logic              app_rd_data_valid = 0, app_rd_data_end = 0;
  logic [DATA_W-1:0] app_wdf_data;
  logic [DATA_W-1:0] app_rd_data = '0;

  int n_vec = 0;
  int n_err = 0;
  int g0 = 0, g1 = 0, wk0 = 0, wk1 = 0;

  always #5 clk = ~clk;

  mig_ui_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_wack(r0_wack), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_wack(r1_wack), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
    .rd_err(rd_err)
  );

  // Pulse counters, sampled mid-cycle after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (r0_gnt)  g0++;
    if (r1_gnt)  g1++;
    if (r0_wack) wk0++;
    if (r1_wack) wk1++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic last, input logic [127:0] d, input logic e0, input logic e1,
                      input string tag);
    app_rd_data_valid = 1'b1;
    app_rd_data_end   = last;
    app_rd_data       = d;
    #1;
    chk({tag, "_rv0"}, r0_rvalid, e0);
    chk({tag, "_rv1"}, r1_rvalid, e1);
    chk({tag, "_rdata"}, r1_rdata, d);
    @(negedge clk);
    app_rd_data_valid = 1'b0;
    app_rd_data_end   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int b0, b1, bw0, bw1, found, ng;
    int seq [6];
    logic [127:0] w0, w1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_app_en", app_en, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_wend", app_wdf_end, 0);
    chk("rst_gnt", {r0_gnt, r1_gnt}, 0);
    chk("rst_wack", {r0_wack, r1_wack}, 0);
    chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_addr", app_addr, 0);
    chk("rst_cmd", app_cmd, 0);
    chk("rst_wdata", app_wdf_data, 0);

    // Two reads requested together out of reset; r0 wins first.
    @(negedge clk);
    r0_req = 1; r0_we = 0; r0_addr = 27'h00020C0;
    r1_req = 1; r1_we = 0; r1_addr = 27'h00010E0;
    app_rdy = 1;
    rst = 0;
    @(negedge clk); #1;
    chk("t1_en_c1", app_en, 1);
    chk("t1_cmd_c1", app_cmd, 3'b001);
    chk("t1_addr_c1", app_addr, 27'h00020C0);
    chk("t1_r0gnt", r0_gnt, 1);
    chk("t1_r1gnt_c1", r1_gnt, 0);
    r0_req = 0;
    @(negedge clk); #1;
    chk("t1_en_gap", app_en, 0);
    @(negedge clk); #1;
    chk("t1_en_c3", app_en, 1);
    chk("t1_addr_c3", app_addr, 27'h00010E0);
    chk("t1_r1gnt", r1_gnt, 1);
    chk("t1_r0gnt_c3", r0_gnt, 0);
    r1_req = 0;
    @(negedge clk);
    beat(0, 128'hA0, 1, 0, "t1_b1");
    beat(1, 128'hA1, 1, 0, "t1_b2");
    beat(0, 128'hA2, 0, 1, "t1_b3");
    beat(1, 128'hA3, 0, 1, "t1_b4");
    chk("t1_no_rderr", rd_err, 0);

    // r1 write with the write FIFO stalled for three cycles in WD0.
    bw1 = wk1;
    w0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    w1 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
    r1_req = 1; r1_we = 1; r1_addr = 27'h00060C0; r1_wdata = w0; app_wdf_rdy = 0;
    @(negedge clk); #1;
    chk("t2_gnt", r1_gnt, 1);
    chk("t2_cmd", app_cmd, 3'b000);
    chk("t2_addr", app_addr, 27'h00060C0);
    r1_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t2_stall_wren", app_wdf_wren, 1);
      chk("t2_stall_end", app_wdf_end, 0);
      chk("t2_stall_data", app_wdf_data, w0);
      chk("t2_stall_wack", r1_wack, 0);
    end
    @(negedge clk);
    app_wdf_rdy = 1; #1;
    chk("t2_b0_data", app_wdf_data, w0);
    chk("t2_b0_wack", r1_wack, 1);
    @(negedge clk);
    r1_wdata = w1; #1;
    chk("t2_b1_wren", app_wdf_wren, 1);
    chk("t2_b1_end", app_wdf_end, 1);
    chk("t2_b1_data", app_wdf_data, w1);
    @(negedge clk);
    app_wdf_rdy = 0; #1;
    chk("t2_done_wren", app_wdf_wren, 0);
    chk("t2_wack_total", wk1 - bw1, 2);

    // Eight outstanding r0 reads fill the tag FIFO.
    b0 = g0;
    r0_req = 1; r0_we = 0; r0_addr = 27'h0000100;
    for (int c = 0; c < 40 && (g0 - b0) < 8; c++) @(negedge clk);
    chk("t3_eight_reads", g0 - b0, 8);
    b0 = g0; b1 = g1; bw1 = wk1;
    r1_req = 1; r1_we = 1; r1_addr = 27'h0000200; r1_wdata = w0; app_wdf_rdy = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (r1_gnt) r1_req = 0;
    end
    chk("t3_r0_blocked", g0 - b0, 0);
    chk("t3_r1_write_gnt", g1 - b1, 1);
    chk("t3_r1_wacks", wk1 - bw1, 2);
    beat(0, 128'hB0, 1, 0, "t3_b1");
    beat(1, 128'hB1, 1, 0, "t3_b2");
    found = 0;
    for (int c = 0; c < 6 && found == 0; c++) begin
      #1;
      if (r0_gnt) found = 1;
      else @(negedge clk);
    end
    chk("t3_ninth_issued", found, 1);
    r0_req = 0;

    // Reset in the middle of a write burst.
    @(negedge clk);
    r0_req = 1; r0_we = 1; r0_addr = 27'h0000300; r0_wdata = w1; app_wdf_rdy = 0;
    @(negedge clk); #1;
    chk("t5_wr_gnt", r0_gnt, 1);
    r0_req = 0;
    @(negedge clk); #1;
    chk("t5_in_wd0", app_wdf_wren, 1);
    rst = 1; #1;
    chk("t5_rst_wren", app_wdf_wren, 0);
    chk("t5_rst_en", app_en, 0);
    chk("t5_rst_wdata", app_wdf_data, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Read data with no outstanding tag.
    app_rd_data_valid = 1; app_rd_data_end = 1; app_rd_data = 128'hDEAD; #1;
    chk("t4_rv0", r0_rvalid, 0);
    chk("t4_rv1", r1_rvalid, 0);
    @(negedge clk);
    app_rd_data_valid = 0; app_rd_data_end = 0; #1;
    chk("t4_rd_err", rd_err, 1);

    // Both requesters hold reads continuously.
    r0_req = 1; r0_we = 0; r0_addr = 27'h0000400;
    r1_req = 1; r1_we = 0; r1_addr = 27'h0000500;
    ng = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk); #1;
      if (r0_gnt) begin seq[ng] = 0; ng++; end
      else if (r1_gnt) begin seq[ng] = 1; ng++; end
    end
    r0_req = 0; r1_req = 0;
    chk("t6_ngrants", ng, 6);
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      chk($sformatf("t6_gnt%0d", i), seq[i], 0);
`else
      chk($sformatf("t6_gnt%0d", i), seq[i], i % 2);
`endif
    end
    @(negedge clk);
    beat(0, 128'hC0, 1, 0, "t6_b1");
    beat(1, 128'hC1, 1, 0, "t6_b2");
`ifdef ARB_FIXED_PRIO_EN
    beat(0, 128'hC2, 1, 0, "t6_b3");
    beat(1, 128'hC3, 1, 0, "t6_b4");
`else
    beat(0, 128'hC2, 0, 1, "t6_b3");
    beat(1, 128'hC3, 0, 1, "t6_b4");
`endif
    #1;
    chk("t6_rd_err_sticky", rd_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mig_ui_arbiter.md
Name: mig_ui_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the MIG user-interface command, write-data and read-data ports.
- Replaces the fixed read-address ROM test driver. Requesters are cache fill (r0) and writeback/DMA (r1).
- Shares the single MIG command port, pushes 2-beat write bursts, and routes in-order read returns to the issuing requester through a tag FIFO.

Parameters:
- ADDR_W, 27, MIG app_addr width
- DATA_W, 128, MIG app data width (one beat)
- TAG_DEPTH, 8, maximum outstanding reads (power of 2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rN_req  in  1  request, N=0,1; held until rN_gnt
- rN_we  in  1  1 = write, 0 = read; stable while rN_req
- rN_addr  in  ADDR_W  burst address; stable while rN_req
- rN_wdata  in  DATA_W  current write beat; held until rN_wack
- rN_gnt  out  1  command accepted by MIG (1-cycle pulse)
- rN_wack  out  1  write beat consumed (1-cycle pulse)
- rN_rdata  out  DATA_W  read data (app_rd_data broadcast)
- rN_rvalid  out  1  read beat valid for requester N
- app_addr  out  ADDR_W  MIG command address
- app_cmd  out  3  3'b000 write, 3'b001 read
- app_en  out  1  command valid
- app_rdy  in  1  MIG command accept
- app_wdf_data  out  DATA_W  write beat
- app_wdf_wren  out  1  write beat valid
- app_wdf_end  out  1  last beat of burst
- app_wdf_rdy  in  1  MIG write FIFO accept
- app_rd_data  in  DATA_W  read beat
- app_rd_data_valid  in  1  read beat valid
- app_rd_data_end  in  1  last read beat of burst
- rd_err  out  1  sticky: read data arrived with no outstanding tag

Behaviour:
- Reset (async): state=IDLE; app_en, app_wdf_wren, app_wdf_end, rN_gnt, rN_wack, rN_rvalid, rd_err all 0; app_addr, app_cmd, app_wdf_data 0; tag FIFO empty (count 0); last_gnt=1, so r0 wins first.
- Eligibility: rN_req & (rN_we | tag_count<TAG_DEPTH). A read is never issued while the tag FIFO is full; writes are unaffected.
- IDLE: if any requester is eligible, select one round-robin (the requester not equal to last_gnt wins a tie). Latch sel, we, addr into registers. Next state is CMD. Decision latency: app_en rises the cycle after rN_req is sampled.
- CMD: app_en=1; app_cmd from latched we; app_addr=latched addr. Hold until app_rdy=1.
- On the app_rdy cycle:
  - r{sel}_gnt=1 (combinational with acceptance).
  - Read: push sel into the tag FIFO, set last_gnt=sel, go to IDLE.
  - Write: go to WD0.
- WD0: app_wdf_wren=1, app_wdf_end=0, app_wdf_data=r{sel}_wdata. On app_wdf_rdy: r{sel}_wack=1, go to WD1.
- WD1: same as WD0 but app_wdf_end=1. On app_wdf_rdy: r{sel}_wack=1, set last_gnt=sel, go to IDLE.
- A new request is never considered before IDLE; minimum spacing is 2 cycles per read command and 4 per write.
- Read return:
  - rN_rdata=app_rd_data for both N.
  - rN_rvalid=app_rd_data_valid & fifo_not_empty & (head==N).
  - Pop on app_rd_data_valid & app_rd_data_end & not empty.
  - Simultaneous push and pop: count unchanged; the pushed entry lands behind head.
  - Push when count==TAG_DEPTH: impossible by the eligibility rule.
- app_rd_data_valid with an empty FIFO: no rvalid, no pop, rd_err set until rst.
- Tag FIFO pointers are log2(TAG_DEPTH) bits and wrap modulo TAG_DEPTH; count is log2(TAG_DEPTH)+1 bits.
- Reset mid-burst: the command or write beat is abandoned immediately. The requester must reissue.

Optional Feature:
- ARB_FIXED_PRIO_EN
  - Defined: r0 always wins when both requesters are eligible; last_gnt is ignored.
  - Undefined: round-robin as above.

Test Plan:
- r0 read 0x00020C0 and r1 read 0x00010E0 both requested in the cycle after reset, app_rdy=1 -> app_en at cycle 1 with cmd 001 and addr 0x00020C0 (r0_gnt), then 0x00010E0 (r1_gnt). Return of 4 beats with end on beats 2 and 4 -> r0_rvalid on beats 1-2, r1_rvalid on beats 3-4.
- r1 write 0x00060C0 with app_wdf_rdy low for 3 cycles in WD0 -> wren held, data equals r1_wdata beat 0, r1_wack only on the rdy cycle. Second beat has app_wdf_end=1; 2 wack pulses total.
- r0 issues 8 reads with no return -> a 9th r0 read is not issued while an r1 write is issued; one completed return burst -> the 9th read issues.
- app_rd_data_valid=1 with the tag FIFO empty -> rd_err=1 and stays 1, no rvalid, count stays 0.
- rst asserted during WD0 -> app_wdf_wren and app_en are 0 in the same cycle; after release the state is IDLE, count is 0, and the first grant goes to r0.
- Both requesters hold reads continuously -> grants alternate r0,r1,r0,r1. With ARB_FIXED_PRIO_EN defined -> r0 gets every grant until the FIFO is full.
